// File: rtl/app_dram_model.sv
// Behavioural-but-synthesizable stand-in for a MIG APP-interface DDR3 controller.
// One-beat 128-bit lines, calibration delay, periodic refresh back-pressure, fixed read latency.
`timescale 1ns/1ps
module app_dram_model #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_CMD_WIDTH  = 3,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int MEM_LINES_LOG2 = 10,
    parameter int CALIB_CYCLES   = 16,
    parameter int READ_LATENCY   = 4,
    parameter int REFRESH_PERIOD = 64,
    parameter int REFRESH_BUSY   = 4
) (
    input  logic                      CLK,
    input  logic                      RST_X,
    output logic                      o_init_calib_complete,
    input  logic [APP_ADDR_WIDTH-1:0] i_app_addr,
    input  logic [APP_CMD_WIDTH-1:0]  i_app_cmd,
    input  logic                      i_app_en,
    output logic                      o_app_rdy,
    input  logic [APP_DATA_WIDTH-1:0] i_app_wdf_data,
    input  logic [APP_MASK_WIDTH-1:0] i_app_wdf_mask,
    input  logic                      i_app_wdf_wren,
    input  logic                      i_app_wdf_end,
    output logic                      o_app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0] o_app_rd_data,
    output logic                      o_app_rd_data_valid,
    output logic                      o_app_rd_data_end,
    output logic [1:0]                o_dbg_state
);
    // Handshake: a command transfers on a rising edge where i_app_en & o_app_rdy,
    // a write beat where i_app_wdf_wren & o_app_wdf_rdy; both ready signals decode flops only.
    localparam int CAL_W  = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int REF_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int BUSY_W = (REFRESH_BUSY > 0) ? $clog2(REFRESH_BUSY + 1) : 1;
    localparam logic [CAL_W-1:0]  CAL_LAST  = CAL_W'(CALIB_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'((REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(REFRESH_BUSY);
    localparam logic [APP_CMD_WIDTH-1:0] CMD_WR = '0;
    localparam logic [APP_CMD_WIDTH-1:0] CMD_RD = APP_CMD_WIDTH'(1);

    typedef enum logic [1:0] {S_CALIB, S_IDLE, S_WR_WAIT, S_RD_WAIT} state_e;

    state_e                    state_q, state_d;
    logic [CAL_W-1:0]          cal_cnt_q, cal_cnt_d;
    logic                      calib_done_q, calib_done_d;
    logic [MEM_LINES_LOG2-1:0] idx_q, idx_d;
    logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
    logic [REF_W-1:0]          ref_cnt_q, ref_cnt_d;
    logic [BUSY_W-1:0]         busy_cnt_q, busy_cnt_d;
    logic                      buf_full_q, buf_full_d;
    logic [APP_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [APP_MASK_WIDTH-1:0] buf_mask_q, buf_mask_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [APP_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [APP_DATA_WIDTH-1:0] line_mem [0:(1<<MEM_LINES_LOG2)-1];

    logic refresh_active, app_rdy, wdf_rdy, cmd_acc, wdf_acc, mem_we;
    logic unused_bits;

    assign unused_bits = ^{i_app_wdf_end, i_app_addr[APP_ADDR_WIDTH-1:MEM_LINES_LOG2+3], i_app_addr[2:0]};

    always_comb begin
        state_d        = state_q;
        cal_cnt_d      = cal_cnt_q;
        calib_done_d   = calib_done_q;
        idx_d          = idx_q;
        lat_cnt_d      = lat_cnt_q;
        ref_cnt_d      = ref_cnt_q;
        busy_cnt_d     = busy_cnt_q;
        buf_full_d     = buf_full_q;
        buf_data_d     = buf_data_q;
        buf_mask_d     = buf_mask_q;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        mem_we         = 1'b0;
        refresh_active = (busy_cnt_q != '0);
        app_rdy        = (state_q == S_IDLE) && !refresh_active;
        wdf_rdy        = calib_done_q && !buf_full_q;
        cmd_acc        = i_app_en && app_rdy;
        wdf_acc        = i_app_wdf_wren && wdf_rdy;

        if (wdf_acc) begin
            buf_full_d = 1'b1;
            buf_data_d = i_app_wdf_data;
            buf_mask_d = i_app_wdf_mask;
        end

        case (state_q)
            S_CALIB: begin
                if (cal_cnt_q == CAL_LAST) begin
                    state_d      = S_IDLE;
                    calib_done_d = 1'b1;
                end else begin
                    cal_cnt_d = cal_cnt_q + CAL_W'(1);
                end
            end
            S_IDLE: begin
                if (cmd_acc && i_app_cmd == CMD_WR) begin
                    idx_d   = i_app_addr[MEM_LINES_LOG2+2:3];
                    state_d = S_WR_WAIT;
                end else if (cmd_acc && i_app_cmd == CMD_RD) begin
                    idx_d     = i_app_addr[MEM_LINES_LOG2+2:3];
                    lat_cnt_d = LAT_LAST;
                    state_d   = S_RD_WAIT;
                end
            end
            S_WR_WAIT: begin
                // wdf_rdy is low while full, so a new beat can never collide with this commit
                if (buf_full_q) begin
                    mem_we     = 1'b1;
                    buf_full_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = line_mem[idx_q];
                    state_d    = S_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = S_CALIB;
        endcase

        // Refresh only masks app_rdy; work already accepted is never stalled by it.
        if (REFRESH_PERIOD != 0 && calib_done_q) begin
            if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - BUSY_W'(1);
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_d  = '0;
                busy_cnt_d = BUSY_LOAD;
            end else begin
                ref_cnt_d = ref_cnt_q + REF_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= S_CALIB;
            cal_cnt_q    <= '0;
            calib_done_q <= 1'b0;
            idx_q        <= '0;
            lat_cnt_q    <= '0;
            ref_cnt_q    <= '0;
            busy_cnt_q   <= '0;
            buf_full_q   <= 1'b0;
            buf_data_q   <= '0;
            buf_mask_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cal_cnt_q    <= cal_cnt_d;
            calib_done_q <= calib_done_d;
            idx_q        <= idx_d;
            lat_cnt_q    <= lat_cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            buf_full_q   <= buf_full_d;
            buf_data_q   <= buf_data_d;
            buf_mask_q   <= buf_mask_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // The line store survives reset so data written before a reset can still be read back.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < APP_MASK_WIDTH; b++) begin
                if (!buf_mask_q[b]) line_mem[idx_q][b*8 +: 8] <= buf_data_q[b*8 +: 8];
            end
        end
    end

    assign o_init_calib_complete = calib_done_q;
    assign o_app_rdy             = app_rdy;
    assign o_app_wdf_rdy         = wdf_rdy;
    assign o_app_rd_data         = rd_data_q;
    assign o_app_rd_data_valid   = rd_valid_q;
    assign o_app_rd_data_end     = rd_valid_q;
    assign o_dbg_state           = state_q;
endmodule

// File: tb/tb_app_dram_model.sv
// Bench for app_dram_model: directed steps plus randomized traffic checked against a
// line-array memory model with byte-mask semantics and an expected-read queue.
`timescale 1ns/1ps
module tb_app_dram_model;
    logic         CLK = 1'b0;
    logic         RST_X = 1'b0;
    logic         init_calib_complete;
    logic [27:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_rdy;
    logic [127:0] wdf_data = '0;
    logic [15:0]  wdf_mask = '0;
    logic         wdf_wren = 1'b0;
    logic         wdf_end = 1'b0;
    logic         wdf_rdy;
    logic [127:0] rd_data;
    logic         rd_valid;
    logic         rd_end;
    logic [1:0]   dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    logic [127:0] model_mem [int];
    logic [127:0] exp_q [$];
    int pool [8];

    app_dram_model dut (
        .CLK(CLK), .RST_X(RST_X),
        .o_init_calib_complete(init_calib_complete),
        .i_app_addr(app_addr), .i_app_cmd(app_cmd), .i_app_en(app_en), .o_app_rdy(app_rdy),
        .i_app_wdf_data(wdf_data), .i_app_wdf_mask(wdf_mask), .i_app_wdf_wren(wdf_wren),
        .i_app_wdf_end(wdf_end), .o_app_wdf_rdy(wdf_rdy),
        .o_app_rd_data(rd_data), .o_app_rd_data_valid(rd_valid), .o_app_rd_data_end(rd_end),
        .o_dbg_state(dbg_state)
    );

    // clock / reset-independent monitors
    always #5 CLK = ~CLK;
    always @(negedge CLK) if (rd_valid) valid_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int line_of(input logic [27:0] a);
        return int'((a >> 3) & 28'd1023);
    endfunction

    // Any address that maps to the given line, with junk in the ignored bits.
    function automatic logic [27:0] alias_addr(input int idx);
        logic [27:0] a;
        a = 28'($urandom());
        a[12:3] = idx[9:0];
        return a;
    endfunction

    task automatic model_write(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
        logic [127:0] line;
        int idx;
        idx = line_of(addr);
        line = model_mem.exists(idx) ? model_mem[idx] : 'x;
        for (int b = 0; b < 16; b++) if (!mask[b]) line[b*8 +: 8] = data[b*8 +: 8];
        model_mem[idx] = line;
    endtask

    // driver tasks
    task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
        int n = 0;
        app_en = 1'b1; app_cmd = cmd; app_addr = addr;
        while (!app_rdy && n < 500) begin tick(); n++; end
        check("cmd_accept_bound", 128'(n < 500), 128'(1));
        tick();
        app_en = 1'b0;
    endtask

    task automatic send_data(input logic [127:0] data, input logic [15:0] mask);
        int n = 0;
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = data; wdf_mask = mask;
        while (!wdf_rdy && n < 500) begin tick(); n++; end
        check("data_accept_bound", 128'(n < 500), 128'(1));
        tick();
        wdf_wren = 1'b0; wdf_end = 1'b0;
    endtask

    task automatic write_line(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
        bit c_done = 0;
        bit d_done = 0;
        int n = 0;
        app_en = 1'b1; app_cmd = 3'b000; app_addr = addr;
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = data; wdf_mask = mask;
        while (!(c_done && d_done) && n < 500) begin
            if (app_en && app_rdy) c_done = 1;
            if (wdf_wren && wdf_rdy) d_done = 1;
            tick(); n++;
            if (c_done) app_en = 1'b0;
            if (d_done) begin wdf_wren = 1'b0; wdf_end = 1'b0; end
        end
        check("write_handshake", 128'({c_done, d_done}), 128'(2'b11));
        model_write(addr, data, mask);
    endtask

    task automatic read_line(input logic [27:0] addr, output logic [127:0] data, output int lat);
        send_cmd(3'b001, addr);
        lat = 0;
        while (!rd_valid && lat < 50) begin tick(); lat++; end
        data = rd_data;
        check("rd_data_end", 128'(rd_end), 128'(1));
        tick();
        check("rd_valid_one_cycle", 128'(rd_valid), 128'(0));
    endtask

    task automatic wait_calib(input string tag);
        int n = 0;
        while (!init_calib_complete && n < 100) begin
            check({tag, "_app_rdy_low"}, 128'(app_rdy), 128'(0));
            check({tag, "_wdf_rdy_low"}, 128'(wdf_rdy), 128'(0));
            tick(); n++;
        end
        check({tag, "_cycles"}, 128'(n), 128'(16));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_calib"}, 128'(init_calib_complete), 128'(0));
        check({tag, "_app_rdy"}, 128'(app_rdy), 128'(0));
        check({tag, "_wdf_rdy"}, 128'(wdf_rdy), 128'(0));
        check({tag, "_rd_valid"}, 128'(rd_valid), 128'(0));
        check({tag, "_rd_end"}, 128'(rd_end), 128'(0));
        check({tag, "_rd_data"}, rd_data, 128'(0));
    endtask

    initial begin
        logic [127:0] got, prior, exp;
        int lat, base, acc, vcnt, run_len, run_start, runs;
        bit in_run, seen_high;

        for (int i = 0; i < 8; i++) pool[i] = 100 + i * 37;

        // reset state
        tick(); tick();
        check_reset_outputs("reset");

        // calibration: commands and data offered during it must be ignored
        RST_X = 1'b1;
        app_en = 1'b1; app_cmd = 3'b001; app_addr = 28'h10;
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = '1; wdf_mask = '0;
        base = valid_cnt;
        wait_calib("calib");
        app_en = 1'b0; wdf_wren = 1'b0; wdf_end = 1'b0;
        check("calib_flag", 128'(init_calib_complete), 128'(1));
        check("calib_data_ignored", 128'(wdf_rdy), 128'(1));
        repeat (8) tick();
        check("calib_cmd_ignored", 128'(valid_cnt - base), 128'(0));

        // same-edge write then read, latency 4
        write_line(28'h10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0000);
        read_line(28'h10, got, lat);
        check("basic_rd_data", got, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        check("basic_rd_latency", 128'(lat), 128'(4));

        // byte mask: only bytes [3:0] written
        prior = {$urandom(), $urandom(), $urandom(), $urandom()};
        write_line(28'h18, prior, 16'h0000);
        write_line(28'h18, '1, 16'hFFF0);
        read_line(28'h18, got, lat);
        check("mask_rd_data", got, {prior[127:32], 32'hFFFF_FFFF});
        check("mask_model", got, model_mem[line_of(28'h18)]);

        // data beat three cycles ahead of its command
        send_data({16{8'hA5}}, 16'h0000);
        check("early_data_wdf_rdy_low", 128'(wdf_rdy), 128'(0));
        tick(); tick();
        send_cmd(3'b000, 28'h20);
        check("early_data_still_full", 128'(wdf_rdy), 128'(0));
        tick();
        check("early_data_wdf_rdy_back", 128'(wdf_rdy), 128'(1));
        model_write(28'h20, {16{8'hA5}}, 16'h0000);
        read_line(28'h20, got, lat);
        check("early_data_rd", got, {16{8'hA5}});

        // unknown command is swallowed without a response
        base = valid_cnt;
        send_cmd(3'b011, 28'h10);
        repeat (10) tick();
        check("bad_cmd_no_valid", 128'(valid_cnt - base), 128'(0));
        read_line(28'h10, got, lat);
        check("bad_cmd_then_read", got, model_mem[line_of(28'h10)]);

        // randomized traffic against the model, with address aliasing
        foreach (pool[i]) write_line(alias_addr(pool[i]), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0000);
        for (int k = 0; k < 60; k++) begin
            int idx;
            idx = pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 2))
                0: write_line(alias_addr(idx), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0000);
                1: write_line(alias_addr(idx), {$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()));
                default: begin
                    read_line(alias_addr(idx), got, lat);
                    check("rand_rd_data", got, model_mem[idx]);
                    check("rand_rd_latency", 128'(lat), 128'(4));
                end
            endcase
        end

        // refresh windows observed while idle
        in_run = 0; seen_high = 0; runs = 0; run_len = 0; run_start = -1;
        for (int c = 0; c < 300; c++) begin
            if (!app_rdy) begin
                if (!in_run && seen_high) begin
                    in_run = 1;
                    if (run_start >= 0) check("refresh_period", 128'(c - run_start), 128'(64));
                    run_start = c;
                    run_len = 0;
                end
                if (in_run) run_len++;
            end else begin
                seen_high = 1;
                if (in_run) begin
                    check("refresh_busy_len", 128'(run_len), 128'(4));
                    runs++;
                    in_run = 0;
                end
            end
            tick();
        end
        check("refresh_windows_seen", 128'(runs >= 3), 128'(1));

        // app_en held high with a stream of reads across refresh windows
        acc = 0; vcnt = 0; exp_q.delete();
        for (int c = 0; c < 300 + 20; c++) begin
            if (c < 300) begin
                logic [27:0] a;
                a = alias_addr(pool[$urandom_range(0, 7)]);
                app_en = 1'b1; app_cmd = 3'b001; app_addr = a;
                if (app_rdy) begin
                    exp_q.push_back(model_mem[line_of(a)]);
                    acc++;
                end
            end else begin
                app_en = 1'b0;
            end
            tick();
            if (rd_valid) begin
                vcnt++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("stream_rd_data", rd_data, exp);
            end
        end
        check("stream_read_count", 128'(vcnt), 128'(acc));
        check("stream_queue_empty", 128'(exp_q.size()), 128'(0));
        check("stream_accepts", 128'(acc > 30), 128'(1));

        // reset while a read is outstanding
        send_cmd(3'b001, 28'h18);
        tick();
        #2 RST_X = 1'b0;
        #1 check_reset_outputs("midrd_reset");
        base = valid_cnt;
        tick(); tick(); tick();
        RST_X = 1'b1;
        wait_calib("recal");
        repeat (8) tick();
        check("midrd_no_valid", 128'(valid_cnt - base), 128'(0));
        read_line(28'h10, got, lat);
        check("midrd_store_kept", got, model_mem[line_of(28'h10)]);
        check("midrd_store_value", got, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
